// File: rtl/rc_rr_event_arbiter.sv
// Two-level round-robin event arbiter: picks a requesting row fairly, snapshots its
// column requests, and streams one (row, column) address per valid/ready handshake.
module rc_rr_event_arbiter #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 8,
  parameter int unsigned ROW_AW = $clog2(ROWS),
  parameter int unsigned COL_AW = $clog2(COLS)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic [ROWS-1:0][COLS-1:0] req_i,
  input  logic                      evt_ready_i,
  output logic [ROWS-1:0]           x_gnt_o,
  output logic [COLS-1:0]           y_gnt_o,
  output logic [ROW_AW-1:0]         x_add_o,
  output logic [COL_AW-1:0]         y_add_o,
  output logic                      evt_valid_o,
  output logic                      grp_release_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COL_ARB = 2'd1,
    OUT     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q;
  logic [ROW_AW-1:0] row_ptr_q;
  logic [COLS-1:0]   col_mask_q;

  logic [ROWS-1:0]   row_any;
  logic              row_found;
  logic [ROW_AW-1:0] row_sel;
  logic [ROW_AW-1:0] row_ptr_nxt;
  logic              col_found;
  logic [COL_AW-1:0] col_sel;
  logic [COLS-1:0]   col_bit;
  logic              handshake;

  // Per-row activity flag
  always_comb begin
    row_any = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      row_any[r] = |req_i[r];
    end
  end

  // Round-robin row search: first active row at or above the pointer, else wrap to the lowest
  always_comb begin
    row_found = 1'b0;
    row_sel   = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!row_found && row_any[r] && (r >= 32'(row_ptr_q))) begin
        row_found = 1'b1;
        row_sel   = ROW_AW'(r);
      end
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!row_found && row_any[r]) begin
        row_found = 1'b1;
        row_sel   = ROW_AW'(r);
      end
    end
    row_ptr_nxt = (32'(row_sel) == (ROWS - 1)) ? '0 : row_sel + ROW_AW'(1);
  end

  // Lowest pending column of the snapshotted group
  always_comb begin
    col_found = 1'b0;
    col_sel   = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (!col_found && col_mask_q[c]) begin
        col_found = 1'b1;
        col_sel   = COL_AW'(c);
      end
    end
    col_bit = COLS'(1) << col_sel;
  end

  assign handshake = evt_valid_o && evt_ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      row_ptr_q     <= '0;
      col_mask_q    <= '0;
      x_gnt_o       <= '0;
      y_gnt_o       <= '0;
      x_add_o       <= '0;
      y_add_o       <= '0;
      evt_valid_o   <= 1'b0;
      grp_release_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i && row_found) begin
            x_gnt_o    <= ROWS'(1) << row_sel;
            x_add_o    <= row_sel;
            col_mask_q <= req_i[row_sel];
            row_ptr_q  <= row_ptr_nxt;
            busy_o     <= 1'b1;
            state_q    <= COL_ARB;
          end
        end
        COL_ARB: begin
          col_mask_q  <= col_mask_q & ~col_bit;
          y_gnt_o     <= col_bit;
          y_add_o     <= col_sel;
          evt_valid_o <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (handshake) begin
            if (|col_mask_q) begin
              // Back-to-back: next column goes straight out without revisiting COL_ARB
              col_mask_q <= col_mask_q & ~col_bit;
              y_gnt_o    <= col_bit;
              y_add_o    <= col_sel;
            end else begin
              x_gnt_o       <= '0;
              y_gnt_o       <= '0;
              x_add_o       <= '0;
              y_add_o       <= '0;
              evt_valid_o   <= 1'b0;
              grp_release_o <= 1'b1;
              state_q       <= RELEASE;
            end
          end
        end
        RELEASE: begin
          grp_release_o <= 1'b0;
          busy_o        <= 1'b0;
          state_q       <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rc_rr_event_arbiter.md
# rc_rr_event_arbiter

Parametrised two-level round-robin arbiter for the event-based pixel array. It picks one active row, snapshots that row's column requests as a group, and emits one (row, column) event address per valid/ready handshake. When the group is finished it pulses a group release that clears the pixels. It replaces the fixed 8x8 row/column arbiter pair with a single block that supports any array size, applies back-pressure, and gives fair row rotation.

## Interface
- ROWS, default 8: array rows, ≥2.
- COLS, default 8: array columns, ≥2.
- ROW_AW, default $clog2(ROWS): row address width.
- COL_AW, default $clog2(COLS): column address width.

- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  reset; one clock, synchronous, active-high.
- enable_i  input  1  permits a new group to start.
- req_i  input  ROWS×COLS  pixel requests, req_i[r][c].
- evt_ready_i  input  1  downstream accepts the event.
- x_gnt_o  output  ROWS  one-hot granted row.
- y_gnt_o  output  COLS  one-hot granted column.
- x_add_o  output  ROW_AW  granted row index.
- y_add_o  output  COL_AW  granted column index.
- evt_valid_o  output  1  event address valid.
- grp_release_o  output  1  one-cycle pulse at group end.
- busy_o  output  1  high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, COL_ARB, OUT, RELEASE.
- **IDLE**
  - All grants, evt_valid_o and grp_release_o are 0.
  - If enable_i=1 and any req_i bit is set:
    - Pick a row r round-robin: search starts at row_ptr and wraps ROWS-1 to 0.
    - Register x_gnt_o/x_add_o = r.
    - Snapshot col_mask = req_i[r].
    - Set row_ptr = (r+1) mod ROWS.
    - Go to COL_ARB.
- **COL_ARB**
  - Select the lowest set bit c of col_mask and clear it.
  - Register y_gnt_o/y_add_o = c and set evt_valid_o=1.
  - Go to OUT.
- **OUT**
  - Hold evt_valid_o, x_*, y_* stable until evt_valid_o & evt_ready_i.
  - On handshake with col_mask≠0: load the next lowest column directly and stay in OUT. This gives back-to-back events, one per cycle.
  - On handshake with col_mask=0: go to RELEASE.
- **RELEASE**
  - grp_release_o=1 for exactly one cycle.
  - Grants and evt_valid_o are 0.
  - Go to IDLE.
- **Snapshot semantics**
  - Request bits that deassert after the snapshot are still reported.
  - New bits in the granted row after the snapshot wait for that row's next turn.
  - Other rows' changes have no effect mid-group.
- **enable_i** is sampled only in IDLE. Deasserting it mid-group lets the current group finish.
- **Reset**
  - Any state returns to IDLE; row_ptr=0 and col_mask=0.
  - All outputs are 0 from the edge where reset_i is sampled high, including mid-OUT.
  - No release pulse is produced.
- **Non-power-of-2 ROWS/COLS**
  - The pointer wraps at ROWS-1.
  - Indices ≥ROWS or ≥COLS are never produced.

## Timing
- Requests and enable_i sampled in IDLE at edge 0:
  - edge 1: x_gnt_o valid.
  - edge 2: evt_valid_o=1 with both addresses.
- Event throughput: 1 per cycle while evt_ready_i=1.
- Group overhead: 3 cycles (IDLE pick, COL_ARB, RELEASE).
- grp_release_o asserts on the edge after the last handshake. It is never high together with evt_valid_o.
- While evt_valid_o=1 and evt_ready_i=0: x_gnt_o, y_gnt_o, x_add_o and y_add_o must not change.
- evt_ready_i is ignored when evt_valid_o=0.
- Fairness: a continuously requesting row waits at most ROWS-1 groups.

## Test plan
- **Reset:** assert reset_i for 2 cycles with random req_i and enable_i=1 → all outputs 0, busy_o=0; first grant goes to the lowest active row.
- **Single event:** req_i[2][5]=1, enable_i=1, evt_ready_i=1 →
  - edge1: x_gnt_o=0x04.
  - edge2: evt_valid_o=1, x_add_o=2, y_add_o=5, y_gnt_o=0x20 for one cycle.
  - edge3: grp_release_o=1.
  - edge4: IDLE.
- **Multi-column group:** row 1, columns {0,3,7}, evt_ready_i=1 → events (1,0),(1,3),(1,7) on consecutive cycles, then one release pulse. Clearing req_i mid-group does not drop (1,7).
- **Back-pressure:** hold evt_ready_i low for 3 cycles during event (1,3) → valid and addresses stable for 4 cycles; the next event follows the cycle after ready rises.
- **Row fairness:** rows 0 and 3 request continuously, one column each → x_add_o sequence 0,3,0,3 with a release between each group.
- **Parametric / mid-operation reset:** ROWS=5, COLS=3.
  - Rows 4 and 0 active with row_ptr=4 → row 4 served, then row 0 (wrap).
  - Assert reset_i while in OUT → outputs 0 next edge, no grp_release_o.
